// File: rtl/tmr2_peripheral_if.sv
// ---------------------------------------------------------------------------
// tmr2_peripheral_if
//
// Purpose:
//   Register-bus bundle between the core's external-peripheral port and the
//   Timer2 peripheral.
//
// Signals:
//   addr      9-bit regfile address (extern_peripherals_addr)
//   data_in   8-bit write data (extern_peripherals_data_in, ALU output)
//   wr_en     register-file write strobe, one clk wide per write
//   data_out  8-bit read data back to the core (extern_peripherals_data_out)
//   hit       high when addr selects one of the peripheral's registers
//
// Modports:
//   master  the core side: drives addr/data_in/wr_en, receives data_out/hit
//   slave   the peripheral side
// ---------------------------------------------------------------------------
interface tmr2_peripheral_if;
    logic [8:0] addr;
    logic [7:0] data_in;
    logic       wr_en;
    logic [7:0] data_out;
    logic       hit;

    modport master (
        output addr,
        output data_in,
        output wr_en,
        input  data_out,
        input  hit
    );

    modport slave (
        input  addr,
        input  data_in,
        input  wr_en,
        output data_out,
        output hit
    );
endinterface

// File: rtl/tmr2_peripheral.sv
// ---------------------------------------------------------------------------
// tmr2_peripheral
//
// Purpose:
//   Timer2 peripheral on the core's external-peripheral register bus.
//   Provides TMR2 (8-bit up-counter), PR2 (period register) and T2CON
//   (control) with prescaler, period match and postscaler. Counting is driven
//   by rising edges of the instruction-cycle clock clkout (clk/4), detected
//   in the clk domain. A match that completes a postscale period produces a
//   one-clk tmr2if_set_en strobe for the PIR1 logic.
//
// Ports:
//   clk            in   system clock
//   rst            in   synchronous, active-high reset
//   clkout         in   instruction-cycle clock (clk/4)
//   bus            slave register bus (addr, data_in, wr_en, data_out, hit)
//   tmr2if_set_en  out  one-clk pulse: set PIR1.TMR2IF
//
// Configuration:
//   TMR2_POSTSCALER_EN  when defined, T2CON.TOUTPS selects a 1..16
//                       postscale. When undefined there is no postscaler
//                       counter and every period match pulses
//                       tmr2if_set_en; TOUTPS stays readable/writable.
//
// T2CON layout (7 bits stored, bit 7 reads 0):
//   [6:3] TOUTPS  postscale = TOUTPS+1
//   [2]   TMR2ON  count enable
//   [1:0] T2CKPS  00 -> 1:1, 01 -> 1:4, 1x -> 1:16
// ---------------------------------------------------------------------------
module tmr2_peripheral #(
    parameter logic [8:0] TMR2_ADDR  = 9'h011,
    parameter logic [8:0] T2CON_ADDR = 9'h012,
    parameter logic [8:0] PR2_ADDR   = 9'h092
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clkout,
    tmr2_peripheral_if.slave    bus,
    output logic                tmr2if_set_en
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [7:0] tmr2_q,   tmr2_d;
    logic [7:0] pr2_q,    pr2_d;
    logic [6:0] t2con_q,  t2con_d;
    logic [3:0] pre_q,    pre_d;
    logic       clkout_q;
    logic       set_q,    set_d;
`ifdef TMR2_POSTSCALER_EN
    logic [3:0] post_q,   post_d;
`endif

    // -----------------------------------------------------------------------
    // Decode
    // -----------------------------------------------------------------------
    logic       sel_tmr2, sel_t2con, sel_pr2;
    logic       wr_tmr2,  wr_t2con,  wr_pr2, wr_any;
    logic       clr_scalers;
    logic       tick;
    logic [3:0] pre_last;
    logic       pre_wrap;
    logic       inc;
    logic       match;

    // Full 9-bit compare: bank mirrors of these addresses must not hit.
    assign sel_tmr2  = (bus.addr == TMR2_ADDR);
    assign sel_t2con = (bus.addr == T2CON_ADDR);
    assign sel_pr2   = (bus.addr == PR2_ADDR);

    assign wr_tmr2   = bus.wr_en & sel_tmr2;
    assign wr_t2con  = bus.wr_en & sel_t2con;
    assign wr_pr2    = bus.wr_en & sel_pr2;
    assign wr_any    = wr_tmr2 | wr_t2con | wr_pr2;

    // Writing the counter or its control restarts both scaler chains.
    assign clr_scalers = wr_tmr2 | wr_t2con;

    // -----------------------------------------------------------------------
    // Read path (combinational, no side effects)
    // -----------------------------------------------------------------------
    always_comb begin
        bus.hit      = sel_tmr2 | sel_t2con | sel_pr2;
        bus.data_out = 8'h00;
        if (sel_tmr2) begin
            bus.data_out = tmr2_q;
        end else if (sel_t2con) begin
            bus.data_out = {1'b0, t2con_q};
        end else if (sel_pr2) begin
            bus.data_out = pr2_q;
        end
    end

    // -----------------------------------------------------------------------
    // Tick / prescaler
    // -----------------------------------------------------------------------
    // One tick per instruction cycle: the clk on which clkout is first seen
    // high, gated by TMR2ON.
    assign tick = clkout & ~clkout_q & t2con_q[2];

    // Terminal prescaler count for the selected ratio.
    always_comb begin
        case (t2con_q[1:0])
            2'b00:   pre_last = 4'd0;
            2'b01:   pre_last = 4'd3;
            default: pre_last = 4'd15;
        endcase
    end

    assign pre_wrap = (pre_q == pre_last);

    // A register write in the same clk wins over counting: the written
    // value stands and that clk's increment/match is dropped.
    assign inc   = tick & pre_wrap & ~wr_any;

    // Compare before increment, so the period is PR2+1 incs. When TMR2 was
    // written above PR2 it simply counts through 0xFF -> 0x00 first.
    assign match = inc & (tmr2_q == pr2_q);

    always_comb begin
        pre_d = pre_q;
        if (tick) begin
            pre_d = pre_wrap ? 4'd0 : pre_q + 4'd1;
        end
        if (clr_scalers) begin
            pre_d = 4'd0;
        end
    end

    // -----------------------------------------------------------------------
    // Counter and registers
    // -----------------------------------------------------------------------
    always_comb begin
        tmr2_d = tmr2_q;
        if (wr_tmr2) begin
            tmr2_d = bus.data_in;
        end else if (inc) begin
            tmr2_d = match ? 8'h00 : tmr2_q + 8'd1;
        end
    end

    always_comb begin
        t2con_d = wr_t2con ? bus.data_in[6:0] : t2con_q;
        pr2_d   = wr_pr2   ? bus.data_in      : pr2_q;
    end

    // -----------------------------------------------------------------------
    // Postscaler / interrupt strobe
    // -----------------------------------------------------------------------
`ifdef TMR2_POSTSCALER_EN
    always_comb begin
        post_d = post_q;
        set_d  = 1'b0;
        if (match) begin
            if (post_q == t2con_q[6:3]) begin
                post_d = 4'd0;
                set_d  = 1'b1;
            end else begin
                post_d = post_q + 4'd1;
            end
        end
        // A match never coincides with a write, so this cannot drop a pulse.
        if (clr_scalers) begin
            post_d = 4'd0;
        end
    end
`else
    // Fixed 1:1 postscale: every period match raises the flag.
    assign set_d = match;
`endif

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr2_q   <= 8'h00;
            pr2_q    <= 8'hFF;
            t2con_q  <= 7'h00;
            pre_q    <= 4'd0;
            clkout_q <= 1'b0;
            set_q    <= 1'b0;
        end else begin
            tmr2_q   <= tmr2_d;
            pr2_q    <= pr2_d;
            t2con_q  <= t2con_d;
            pre_q    <= pre_d;
            clkout_q <= clkout;
            set_q    <= set_d;
        end
    end

`ifdef TMR2_POSTSCALER_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            post_q <= 4'd0;
        end else begin
            post_q <= post_d;
        end
    end
`endif

    // Registered strobe: high for the one clk following the match edge.
    assign tmr2if_set_en = set_q;

endmodule

// File: tb/tb_tmr2_peripheral.sv
// ---------------------------------------------------------------------------
// tb_tmr2_peripheral
//
// Directed and randomized register traffic against tmr2_peripheral. A
// behavioural model (tick/incs counted with plain integers) predicts read
// data and the clk index of each tmr2if_set_en pulse; predictions go into
// queues that an independent negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_tmr2_peripheral;

    localparam logic [8:0] A_TMR2  = 9'h011;
    localparam logic [8:0] A_T2CON = 9'h012;
    localparam logic [8:0] A_PR2   = 9'h092;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic clkout = 1'b0;
    logic tmr2if_set_en;

    tmr2_peripheral_if bus ();

    tmr2_peripheral dut (
        .clk           (clk),
        .rst           (rst),
        .clkout        (clkout),
        .bus           (bus),
        .tmr2if_set_en (tmr2if_set_en)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard queues ----------------
    typedef struct {
        int         cyc;
        logic [8:0] addr;
        logic [7:0] data;
        logic       hit;
    } rd_t;

    rd_t rd_q[$];
    int  pulse_q[$];
    rd_t mon_e;

    // ---------------- reference model ----------------
    logic [7:0] m_tmr2;
    logic [7:0] m_pr2;
    logic [6:0] m_t2con;
    int         m_ticks;    // ticks since the last inc
    int         m_matches;  // matches since the last flag
    bit         m_ckq;      // clkout level seen at the previous clk
    int         m_phase = 0;

    function automatic int ratio(input logic [1:0] ck);
        if (ck == 2'b00) return 1;
        if (ck == 2'b01) return 4;
        return 16;
    endfunction

    function automatic void model_read(input logic [8:0] a,
                                       output logic [7:0] d, output logic h);
        d = 8'h00;
        h = 1'b1;
        if (a == A_TMR2)       d = m_tmr2;
        else if (a == A_T2CON) d = {1'b0, m_t2con};
        else if (a == A_PR2)   d = m_pr2;
        else                   h = 1'b0;
    endfunction

    // Advance the model across one clk edge; returns 1 when that edge is a
    // match that raises the interrupt flag.
    function automatic bit model_step(input bit r, input bit w,
                                      input logic [8:0] a, input logic [7:0] d,
                                      input bit ck);
        bit tick;
        bit inc;
        bit pulse;
        pulse = 1'b0;
        inc   = 1'b0;
        if (r) begin
            m_tmr2 = 8'h00; m_pr2 = 8'hFF; m_t2con = 7'h00;
            m_ticks = 0; m_matches = 0; m_ckq = 1'b0;
            return 1'b0;
        end
        tick  = ck && !m_ckq && m_t2con[2];
        m_ckq = ck;
        if (tick) begin
            m_ticks++;
            if (m_ticks == ratio(m_t2con[1:0])) begin
                inc = 1'b1;
                m_ticks = 0;
            end
        end
        if (w && a == A_TMR2) begin
            m_tmr2 = d; m_ticks = 0; m_matches = 0; inc = 1'b0;
        end
        if (w && a == A_T2CON) begin
            m_t2con = d[6:0]; m_ticks = 0; m_matches = 0; inc = 1'b0;
        end
        if (w && a == A_PR2) begin
            m_pr2 = d; inc = 1'b0;
        end
        if (inc) begin
            if (m_tmr2 == m_pr2) begin
                m_tmr2 = 8'h00;
                m_matches++;
`ifdef TMR2_POSTSCALER_EN
                if (m_matches == int'(m_t2con[6:3]) + 1) begin
                    pulse = 1'b1;
                    m_matches = 0;
                end
`else
                pulse = 1'b1;
                m_matches = 0;
`endif
            end else begin
                m_tmr2 = m_tmr2 + 8'd1;
            end
        end
        return pulse;
    endfunction

    // True when the coming clk edge will produce an inc (absent a write).
    function automatic bit would_inc();
        return (((m_phase + 1) % 4) >= 2) && !m_ckq && m_t2con[2] &&
               (m_ticks == ratio(m_t2con[1:0]) - 1);
    endfunction

    // ---------------- driver ----------------
    task automatic cycle(input bit r, input bit w,
                         input logic [8:0] a, input logic [7:0] d);
        bit   ck;
        bit   p;
        rd_t  e;
        @(posedge clk);
        #1;
        m_phase++;
        ck          = ((m_phase % 4) >= 2);
        clkout      = ck;
        rst         = r;
        bus.wr_en   = w;
        bus.addr    = a;
        bus.data_in = d;
        if (mon_en && !r && !w) begin
            e.cyc  = cyc;
            e.addr = a;
            model_read(a, e.data, e.hit);
            rd_q.push_back(e);
        end
        p = model_step(r, w, a, d, ck);
        if (p) pulse_q.push_back(cyc + 1);
    endtask

    task automatic wr(input logic [8:0] a, input logic [7:0] d);
        cycle(1'b0, 1'b1, a, d);
        $display("WR  cyc=%0d addr=%h data=%h", cyc, a, d);
    endtask

    task automatic idle(input int n, input logic [8:0] a);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, a, 8'($urandom));
    endtask

    task automatic write_at_inc(input logic [8:0] a, input logic [7:0] d);
        int n;
        n = 0;
        while (!would_inc() && n < 200) begin
            cycle(1'b0, 1'b0, A_TMR2, 8'h00);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL write_at_inc: no inc within 200 clks (got none, required one)");
        end
        wr(a, d);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_q.size() != 0 && rd_q[0].cyc == cyc) begin
                mon_e = rd_q.pop_front();
                checks++;
                if (bus.data_out !== mon_e.data || bus.hit !== mon_e.hit) begin
                    errors++;
                    $display("FAIL read cyc=%0d addr=%h got data=%h hit=%b required data=%h hit=%b",
                             cyc, mon_e.addr, bus.data_out, bus.hit, mon_e.data, mon_e.hit);
                end
            end
            while (pulse_q.size() != 0 && pulse_q[0] < cyc) begin
                checks++;
                errors++;
                $display("FAIL pulse_missing cyc=%0d got 0 required 1", pulse_q[0]);
                void'(pulse_q.pop_front());
            end
            if (tmr2if_set_en !== 1'b0) begin
                checks++;
                if (pulse_q.size() != 0 && pulse_q[0] == cyc) begin
                    void'(pulse_q.pop_front());
                end else begin
                    errors++;
                    $display("FAIL pulse_unexpected cyc=%0d got %b required 0",
                             cyc, tmr2if_set_en);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [8:0] rd_addrs [7];

    initial begin
        rd_addrs[0] = A_TMR2;  rd_addrs[1] = A_T2CON; rd_addrs[2] = A_PR2;
        rd_addrs[3] = 9'h091;  rd_addrs[4] = 9'h111;  rd_addrs[5] = 9'h192;
        rd_addrs[6] = 9'h000;
        bus.addr = 9'h000; bus.data_in = 8'h00; bus.wr_en = 1'b0;

        cycle(1'b1, 1'b0, A_TMR2, 8'h00);
        cycle(1'b1, 1'b0, A_TMR2, 8'h00);
        mon_en = 1'b1;

        // Reset values and non-hitting addresses.
        idle(1, A_TMR2); idle(1, A_T2CON); idle(1, A_PR2);
        idle(1, 9'h091); idle(1, 9'h111);

        // PR2=3, on, 1:1 / 1:1.
        wr(A_PR2, 8'h03);
        wr(A_T2CON, 8'h04);
        idle(60, A_TMR2);

        // PR2=1, 1:4 prescale.
        wr(A_T2CON, 8'h00);
        wr(A_TMR2, 8'h00);
        wr(A_PR2, 8'h01);
        wr(A_T2CON, 8'h05);
        idle(100, A_TMR2);

        // PR2=0, 1:3 postscale.
        wr(A_T2CON, 8'h00);
        wr(A_TMR2, 8'h00);
        wr(A_PR2, 8'h00);
        wr(A_T2CON, 8'h14);
        idle(60, A_TMR2);

        // 1:16, TMR2 written on an inc clk.
        wr(A_PR2, 8'hFF);
        wr(A_T2CON, 8'h06);
        idle(90, A_TMR2);
        write_at_inc(A_TMR2, 8'h02);
        idle(150, A_TMR2);

        // Stopped timer holds its count, then resumes.
        wr(A_T2CON, 8'h00);
        wr(A_TMR2, 8'h05);
        idle(80, A_TMR2);
        wr(A_T2CON, 8'h04);
        idle(30, A_TMR2);

        // TMR2 above PR2 wraps through 0xFF.
        wr(A_PR2, 8'h02);
        wr(A_TMR2, 8'hFD);
        idle(40, A_TMR2);

        // Randomized segments.
        for (int s = 0; s < 30; s++) begin
            int n;
            wr(A_PR2, ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7)));
            if ($urandom_range(0, 1) == 1) wr(A_TMR2, 8'($urandom_range(0, 9)));
            wr(A_T2CON, {1'b0, 4'($urandom), 1'b1, 2'($urandom)});
            n = $urandom_range(100, 300);
            for (int i = 0; i < n; i++) begin
                int k;
                k = $urandom_range(0, 199);
                if (k < 3)       wr(A_TMR2, 8'($urandom_range(0, 9)));
                else if (k < 5)  wr(A_T2CON, 8'($urandom));
                else if (k < 7)  wr(A_PR2, 8'($urandom_range(0, 9)));
                else if (k < 8)  cycle(1'b1, 1'b0, A_TMR2, 8'h00);
                else             idle(1, rd_addrs[$urandom_range(0, 6)]);
            end
        end

        // Stop counting and drain.
        wr(A_T2CON, 8'h00);
        idle(4, A_TMR2);
        @(negedge clk);
        #1;
        checks++;
        if (pulse_q.size() != 0 || rd_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pulses / %0d reads outstanding, required 0",
                     pulse_q.size(), rd_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tmr2_peripheral.md
Name: tmr2_peripheral

Overview:
- Timer2 peripheral on the core's external-peripheral register bus; downstream consumer of the core's extern address/data outputs.
- Provides TMR2 (8-bit up-counter), PR2 (period register) and T2CON (control), with prescaler, period match and postscaler.
- Emits a one-clk TMR2IF set strobe for the PIR1 logic.
- Counts on the instruction-cycle clock (clkout, clk/4) from the core's tmr0wdt block.

Parameters:
- TMR2_ADDR, 9'h011, regfile address of TMR2
- T2CON_ADDR, 9'h012, regfile address of T2CON
- PR2_ADDR, 9'h092, regfile address of PR2

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- clkout  in  1  instruction-cycle clock (clk/4); count events derive from its rising edge
- addr  in  9  regfile address (extern_peripherals_addr)
- data_in  in  8  write data (extern_peripherals_data_in, ALU output)
- wr_en  in  1  register-file write strobe; one clk wide per write
- data_out  out  8  read data, feeds extern_peripherals_data_out
- hit  out  1  high when addr matches any of the three addresses
- tmr2if_set_en  out  1  one-clk pulse: set PIR1.TMR2IF

Behaviour:
- Reset (synchronous, rst high at posedge clk):
  - TMR2=8'h00, PR2=8'hFF, T2CON=7'h00.
  - Prescaler count=0, postscaler count=0, clkout_q=0.
  - tmr2if_set_en=0.
  - data_out and hit follow combinationally from addr.
- Reset mid-count aborts all counting and discards any pending pulse.
- T2CON bits:
  - [6:3] TOUTPS: postscale = TOUTPS+1, giving 1..16.
  - [2] TMR2ON.
  - [1:0] T2CKPS: 00 gives 1:1, 01 gives 1:4, 1x gives 1:16.
  - Bit 7 is unimplemented: writes ignored, reads 0.
- Tick:
  - clkout_q registers clkout every clk.
  - tick = clkout & ~clkout_q & TMR2ON.
  - Exactly one tick per instruction cycle.
- Prescaler:
  - 4-bit counter, incremented on tick.
  - inc fires on the tick where the count equals prescale-1; the counter then wraps to 0.
  - At 1:1, inc = tick.
- Count, on inc:
  - If TMR2==PR2: TMR2 becomes 0 and postscaler advances.
  - Otherwise TMR2 becomes TMR2+1, 8-bit.
  - The match check happens before increment, so the period is PR2+1 incs.
  - PR2=0: TMR2 stays 0 and every inc is a match.
  - TMR2>PR2 (after a TMR2 write): counts up, wraps 0xFF to 0x00 without a match, then matches normally.
- Postscaler:
  - 4-bit counter, advanced on match.
  - When count==TOUTPS: pulse tmr2if_set_en for one clk in the cycle after the match edge, and the counter becomes 0.
  - Otherwise the counter increments.
- Writes (wr_en & addr match, at posedge clk):
  - TMR2 write: loads data_in; clears the prescaler and postscaler counts.
  - T2CON write: loads data_in[6:0]; clears the prescaler and postscaler counts.
  - PR2 write: loads data_in; counters are untouched.
  - A write in the same clk as inc takes priority: the written value stands and no increment or match occurs that clk.
- TMR2ON=0: TMR2 and both counts hold; registers remain writable.
- Reads:
  - data_out is combinational: the selected register value; T2CON reads {1'b0,T2CON}.
  - 8'h00 when hit=0.
  - Reads have no side effects.
- Address match is full 9-bit; mirrors in other banks do not hit.

Optional Feature:
- Macro TMR2_POSTSCALER_EN.
- Defined: postscaler behaves as specified above.
- Undefined:
  - No postscaler counter.
  - tmr2if_set_en pulses on every match, giving a fixed 1:1 postscale.
  - TOUTPS bits remain writable and readable but have no effect.

Test Plan:
- Reset, then read all three addresses -> TMR2=8'h00, T2CON=8'h00, PR2=8'hFF; read at 9'h091 -> 8'h00, hit=0.
- PR2=3, T2CON=8'h04 (on, 1:1, 1:1) -> TMR2 sequence 0,1,2,3,0; tmr2if_set_en pulses once every 4 instruction cycles, each pulse exactly 1 clk.
- PR2=1, T2CON=8'h05 (1:4 pre) -> TMR2 changes every 4 ticks; pulse every 8 ticks.
- PR2=0, T2CON=8'h14 (post 1:3) -> pulse every 3rd tick. With TMR2_POSTSCALER_EN undefined -> pulse every tick.
- Running 1:16: write TMR2=8'h02 mid-prescale, in the same clk as an inc -> TMR2 reads 8'h02 and the next increment occurs 16 ticks later.
- Write T2CON=8'h00 while TMR2=8'h05 -> TMR2 holds 8'h05 over 20 ticks and no pulse; write 8'h04 -> counting resumes from 8'h05.
